arb_rr4: RTL and testbench
==========================

# arb_rr4

Four-requester round-robin arbiter that shares one resource between four request lines, such as the board switches, and reports the current owner on the two-LED index display. The block sits in front of the LED encoder datapath, so LED index semantics are unchanged. It adds sequential grant ownership, fair rotation, a bounded hold time and a one-cycle hand-over gap, so no two requesters ever own the resource at once.

## Interface
- HOLD_MAX, default 8: maximum consecutive grant cycles for one owner while another requester is waiting; legal range 2..255.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; one clock, reset is asynchronous and active-high.
- req  input  4  request lines, bit i = requester i; level-sensitive, already synchronous to clk.
- gnt  output  4  one-hot grant; 4'b0000 when no owner.
- gnt_idx  output  2  binary index of owner; holds last owner when gnt_vld=0.
- gnt_vld  output  1  1 while gnt is non-zero.
- led  output  2  low-active owner index, always ~gnt_idx.
- led_vld_n  output  1  low-active owner-present LED, always ~gnt_vld.

## Operation
- All outputs are registered. Reset values: gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0, led=2'b11, led_vld_n=1.
- Internal reset values: state=IDLE, hold counter cnt=0, round-robin pointer ptr=2'd3, so the first search starts at requester 0.
- The state machine has three states: IDLE, GRANT and GAP.
- IDLE behaviour:
  - If req is 0, stay in IDLE.
  - Otherwise, arbitrate and go to GRANT.
- Arbitration:
  - Search order is ptr+1, ptr+2, ptr+3, ptr, all mod 4. The first set req bit wins.
  - On a win: winner → gnt_idx and ptr; gnt=1<<winner; cnt=0.
- GRANT, owner o: cnt increments each cycle and saturates at HOLD_MAX-1. Exits are checked in priority order:
  - req[o]=0: go to GAP (voluntary release).
  - cnt==HOLD_MAX-1 and (req & ~(1<<o))!=0: go to GAP (forced rotation).
  - Otherwise stay; gnt is unchanged.
- GAP:
  - gnt=0 and gnt_vld=0 for exactly one cycle.
  - Next edge: arbitrate on current req and go to GRANT; if req=0, go to IDLE.
- A sole requester keeps the grant indefinitely, with cnt saturated.
- A forced-out owner that still requests is searched last, because ptr equals its index.
- cnt width is ceil(log2(HOLD_MAX)). No wrap-around is permitted; cnt saturates.
- Changes on req bits other than the owner's do not disturb an active grant.
- Reset asserted in any state forces all reset values immediately (asynchronous). The first arbitration after reset release happens on the first rising edge with rst=0.

## Timing
- Request to grant from IDLE: req sampled on edge N; gnt valid after edge N+1, so latency is 1 cycle.
- Owner release: req[o] low at edge N; gnt=0 after edge N+1; new gnt after edge N+2 if another request is present.
- Forced rotation: the owner holds gnt for exactly HOLD_MAX cycles, then there is 1 gap cycle, then the next owner.
- With all four requesting continuously, the period per owner is HOLD_MAX+1 cycles and a full rotation is 4·(HOLD_MAX+1).
- gnt, gnt_idx, gnt_vld, led and led_vld_n change on the same edge; they are never skewed.
- Only one gnt bit is high at any cycle. gnt never changes directly from one non-zero value to another.

## Test plan
- Reset mid-grant: assert rst while gnt=4'b0100 → outputs go to gnt=0, led=2'b11, led_vld_n=1 without waiting for a clock edge. After release with req=4'b1111, the first grant is 4'b0001.
- Single request: from IDLE, req=4'b0100 → one cycle later gnt=4'b0100, gnt_idx=2, led=2'b01, led_vld_n=0. Holding req keeps the grant for 50 cycles with no gaps.
- Full contention, HOLD_MAX=4, req=4'b1111:
  - Owner sequence is 0,1,2,3,0; each grant lasts exactly 4 cycles, followed by one all-zero gap cycle.
  - led sequence is 11,10,01,00.
- Voluntary release: owner 1 with req=4'b0011; drop req[1] → 1 gap cycle, then gnt=4'b0001. Drop req[0] as well → IDLE, gnt_vld=0.
- Fairness from pointer: after owner 2 releases, apply req=4'b0101 → gnt=4'b0001 (requester 0 before 2). Repeat with owner 0 releasing → gnt=4'b0100.
- Late requester: owner 3 alone saturated for 20 cycles, then req[1] rises → gnt stays 4'b1000 for exactly 1 more cycle, then gap, then gnt=4'b0010. This holds because cnt is already at HOLD_MAX-1.

Source files
------------

// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with a bounded hold time and a one-cycle
// hand-over gap. Owner index and presence are mirrored onto low-active LEDs.
module arb_rr4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_vld_o,
  output logic [1:0] led_o,
  output logic       led_vld_n_o
);

  localparam int unsigned CntW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      ptr_q;
  logic [3:0]      gnt_q;
  logic [1:0]      gnt_idx_q;
  logic            gnt_vld_q;
  logic [1:0]      led_q;
  logic            led_vld_n_q;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [3:0] win_gnt;
  logic       owner_req;
  logic       others_req;
  logic       hold_done;

  // Round-robin search starting just after the last owner; the last owner is tried last.
  always_comb begin
    logic [1:0] cand;
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    win_gnt    = 4'b0001 << win_idx;
    owner_req  = req_i[gnt_idx_q];
    others_req = |(req_i & ~gnt_q);
    hold_done  = (cnt_q == CntMax);
  end

  // Ownership FSM; every output is a register so all of them switch on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= 2'd3;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'b00;
      gnt_vld_q   <= 1'b0;
      led_q       <= 2'b11;
      led_vld_n_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StGap: begin
          if (win_vld) begin
            state_q     <= StGrant;
            cnt_q       <= '0;
            ptr_q       <= win_idx;
            gnt_q       <= win_gnt;
            gnt_idx_q   <= win_idx;
            gnt_vld_q   <= 1'b1;
            led_q       <= ~win_idx;
            led_vld_n_q <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (!owner_req || (hold_done && others_req)) begin
            // Release or forced rotation: drop the grant for one cycle; gnt_idx keeps the owner.
            state_q     <= StGap;
            gnt_q       <= 4'b0000;
            gnt_vld_q   <= 1'b0;
            led_vld_n_q <= 1'b1;
          end else if (!hold_done) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q     <= StIdle;
          gnt_q       <= 4'b0000;
          gnt_vld_q   <= 1'b0;
          led_vld_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_vld_o   = gnt_vld_q;
  assign led_o       = led_q;
  assign led_vld_n_o = led_vld_n_q;

endmodule

// File: tb/tb_arb_rr4.sv
// Scoreboard bench for arb_rr4 with HOLD_MAX=4: stimulus pushes hand-computed
// expected outputs per cycle, a monitor pops and compares after each rising edge.
module tb_arb_rr4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic [1:0] led;
  logic       led_vld_n;

  int checks;
  int errors;

  typedef struct {
    logic [9:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  arb_rr4 #(.HOLD_MAX(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_vld_o  (gnt_vld),
    .led_o      (led),
    .led_vld_n_o(led_vld_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word from a hand-given grant vector and owner index.
  function automatic logic [9:0] pack(input logic [3:0] g, input logic [1:0] idx);
    logic v;
    v = |g;
    return {g, idx, v, ~idx, ~v};
  endfunction

  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] act;
    act = {gnt, gnt_idx, gnt_vld, led, led_vld_n};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got gnt=%b idx=%b vld=%b led=%b led_vld_n=%b, want gnt=%b idx=%b vld=%b led=%b led_vld_n=%b",
               tag, $time, act[9:6], act[5:4], act[3], act[2:1], act[0],
               exp[9:6], exp[5:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  // Called at a falling edge; applies r for n cycles, expecting (g, idx) after each rising edge.
  task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [1:0] idx,
                       input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      req = r;
      sb_q.push_back('{exp: pack(g, idx), tag: tag});
      @(negedge clk);
    end
  endtask

  // Monitor: one expected entry is consumed per rising edge while the scoreboard is non-empty.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, e.exp);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("reset_values", pack(4'b0000, 2'd0));
    rst = 1'b0;

    // Single requester keeps the grant with no gaps.
    drive(4'b0000, 4'b0000, 2'd0, 1, "idle_no_req");
    drive(4'b0100, 4'b0100, 2'd2, 51, "single_req2");

    // Asynchronous reset in the middle of a grant.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_midgrant", pack(4'b0000, 2'd0));
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    check("reset_held", pack(4'b0000, 2'd0));
    rst = 1'b0;

    // Full contention: owners 0,1,2,3,0, four cycles each, one gap between.
    drive(4'b1111, 4'b0001, 2'd0, 4, "rot_own0");
    drive(4'b1111, 4'b0000, 2'd0, 1, "rot_gap0");
    drive(4'b1111, 4'b0010, 2'd1, 4, "rot_own1");
    drive(4'b1111, 4'b0000, 2'd1, 1, "rot_gap1");
    drive(4'b1111, 4'b0100, 2'd2, 4, "rot_own2");
    drive(4'b1111, 4'b0000, 2'd2, 1, "rot_gap2");
    drive(4'b1111, 4'b1000, 2'd3, 4, "rot_own3");
    drive(4'b1111, 4'b0000, 2'd3, 1, "rot_gap3");
    drive(4'b1111, 4'b0001, 2'd0, 4, "rot_own0_again");
    drive(4'b0000, 4'b0000, 2'd0, 2, "rot_to_idle");

    // Voluntary release: owner 1, then owner 0, then idle.
    drive(4'b0010, 4'b0010, 2'd1, 1, "vol_grant1");
    drive(4'b0011, 4'b0010, 2'd1, 2, "vol_hold1");
    drive(4'b0001, 4'b0000, 2'd1, 1, "vol_gap1");
    drive(4'b0001, 4'b0001, 2'd0, 3, "vol_grant0");
    drive(4'b0000, 4'b0000, 2'd0, 1, "vol_gap0");
    drive(4'b0000, 4'b0000, 2'd0, 2, "vol_idle");

    // Fairness from the pointer.
    drive(4'b0100, 4'b0100, 2'd2, 2, "fair_own2");
    drive(4'b0000, 4'b0000, 2'd2, 1, "fair_rel2");
    drive(4'b0101, 4'b0001, 2'd0, 3, "fair_0_before_2");
    drive(4'b0000, 4'b0000, 2'd0, 1, "fair_rel0");
    drive(4'b0101, 4'b0100, 2'd2, 1, "fair_2_before_0");
    drive(4'b0000, 4'b0000, 2'd2, 2, "fair_to_idle");

    // Late requester against a saturated sole owner.
    drive(4'b1000, 4'b1000, 2'd3, 20, "late_own3");
    drive(4'b1010, 4'b0000, 2'd3, 1, "late_gap");
    drive(4'b1010, 4'b0010, 2'd1, 1, "late_grant1");
    drive(4'b0000, 4'b0000, 2'd1, 2, "late_to_idle");

    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
